// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns, COLS_PER_CYCLE columns per clock; MIX_COLUMNS_INV_EN adds InvMixColumns.
// Latency: OUT_VALID rises 4/COLS_PER_CYCLE edges after accept.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit REG_IN         = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    state_t         state_q, state_d;
    logic [1:0]     col_cnt_q;
    logic [127:0]   work_q;
    logic [127:0]   out_q;
    logic [127:0]   src;
    logic [127:0]   next_work;
    logic [1:0]     grp_idx;
    logic [31:0]    grp_col;
    logic           accept;
    logic           last_grp;
    logic           inv_q;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0]  a [4];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
        for (int i = 0; i < 4; i++)
            r[31-8*i -: 8] = xtime(a[i]) ^ xtime(a[(i+1)%4]) ^ a[(i+1)%4]
                           ^ a[(i+2)%4] ^ a[(i+3)%4];
        return r;
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // 0E/0B/0D/09 products assembled from x2, x4, x8 of each byte
    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0]  a [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++)
            r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                           ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                           ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                           ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)         inv_q <= 1'b0;
        else if (accept) inv_q <= inv;
    end
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign inv_q      = 1'b0;
`endif

    // Without the input register the unit reads in_data live while busy
    assign src      = REG_IN ? work_q : in_data;
    assign last_grp = (col_cnt_q == LAST_CNT);

    always_comb begin
        next_work = work_q;
        grp_idx   = col_cnt_q;
        grp_col   = '0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            grp_idx = col_cnt_q + 2'(k);
            grp_col = src[{~grp_idx, 5'b0} +: 32];
`ifdef MIX_COLUMNS_INV_EN
            next_work[{~grp_idx, 5'b0} +: 32] = inv_q ? mix_inv(grp_col) : mix_fwd(grp_col);
`else
            next_work[{~grp_idx, 5'b0} +: 32] = mix_fwd(grp_col);
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = ~rst;
            BUSY:    if (last_grp) state_d = DONE;
            DONE: begin
                in_ready = out_ready & ~rst;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        accept = in_valid & in_ready;
        if (accept) state_d = BUSY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_cnt_q <= 2'd0;
            work_q    <= '0;
            out_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                col_cnt_q <= 2'd0;
                if (REG_IN) work_q <= in_data;
            end else if (state_q == BUSY) begin
                work_q    <= next_work;
                col_cnt_q <= col_cnt_q + STEP;
                // out_q only moves on completion so partial columns never show
                if (last_grp) out_q <= next_work;
            end
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three instances (1/2/4 columns per cycle, one without input register),
// directed vectors, backpressure, mid-operation reset and a randomized handshake run.
module tb_mix_columns_iter;

`ifdef MIX_COLUMNS_INV_EN
    localparam logic INV_EN = 1'b1;
`else
    localparam logic INV_EN = 1'b0;
`endif

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] COL_IN   = 128'h01010101c6c6c6c6d4d4d4d52d26314c;
    localparam logic [127:0] COL_OUT  = 128'h01010101c6c6c6c6d5d5d7d64d7ebdf8;

    logic                clk = 1'b0;
    logic                rst;
    logic [2:0]          in_valid, in_ready, inv, out_valid, out_ready;
    logic [2:0][127:0]   in_data, out_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mix_columns_iter #(.COLS_PER_CYCLE(1), .REG_IN(1'b1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .inv(inv[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]));

    mix_columns_iter #(.COLS_PER_CYCLE(2), .REG_IN(1'b0)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .inv(inv[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]));

    mix_columns_iter #(.COLS_PER_CYCLE(4), .REG_IN(1'b1)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .inv(inv[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]));

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: shift-and-add GF(2^8) multiply, circulant matrix product per column
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] blk, input logic inv_v);
        logic [7:0]   m [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (inv_v) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else       m = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(m[k], blk[127-32*c-8*((r+k)%4) -: 8]);
                res[127-32*c-8*r -: 8] = acc;
            end
        return res;
    endfunction

    // Offers one block, measures edges from accept to out_valid, then retires it
    task automatic run_block(input int d, input logic [127:0] data, input logic inv_v,
                             output logic [127:0] got, output int lat);
        int w;
        @(negedge clk);
        in_data[d]   = data;
        inv[d]       = inv_v;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b0;
        #1;
        w = 0;
        while (!in_ready[d] && w < 20) begin
            @(negedge clk); #1; w++;
        end
        check_eq($sformatf("accept_d%0d", d), in_ready[d], 1'b1);
        @(negedge clk);
        in_valid[d] = 1'b0;
        lat = 0;
        #1;
        while (!out_valid[d] && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        got = out_data[d];
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    task automatic rand_run(input int d, input int nblk);
        logic [127:0] q[$];
        logic [127:0] exp;
        int  sent = 0;
        int  rcvd = 0;
        int  cyc  = 0;
        bit  need_new = 1'b1;
        bit  busy;
        while (rcvd < nblk && cyc < 40 * nblk) begin
            @(negedge clk);
            cyc++;
            busy = !out_valid[d] && !in_ready[d];
            if (need_new && !busy) begin
                in_data[d] = {$urandom, $urandom, $urandom, $urandom};
                inv[d]     = 1'($urandom);
                need_new   = 1'b0;
            end
            in_valid[d]  = !need_new && (sent < nblk) && ($urandom_range(0, 3) != 0);
            out_ready[d] = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid[d] && out_ready[d]) begin
                exp = (q.size() > 0) ? q.pop_front() : 'x;
                check_eq($sformatf("rand_d%0d_blk%0d", d, rcvd), out_data[d], exp);
                rcvd++;
            end
            if (in_valid[d] && in_ready[d]) begin
                q.push_back(ref_mix(in_data[d], inv[d] & INV_EN));
                sent++;
                need_new = 1'b1;
            end
        end
        check_eq($sformatf("rand_d%0d_count", d), rcvd, nblk);
        check_eq($sformatf("rand_d%0d_leftover", d), q.size(), 0);
        @(negedge clk);
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
    endtask

    initial begin
        logic [127:0] got;
        int           lat;
        int           w;
        logic         seen;

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        inv       = '0;
        in_data   = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rdy_in_reset", in_ready, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 3'b000);
        check_eq("rst_in_ready", in_ready, 3'b111);
        for (int d = 0; d < 3; d++) check_eq($sformatf("rst_out_data_d%0d", d), out_data[d], '0);

        run_block(0, FIPS_IN, 1'b0, got, lat);
        check_eq("fips_data", got, FIPS_OUT);
        check_eq("fips_lat", lat, 4);

        for (int d = 0; d < 3; d++) begin
            run_block(d, COL_IN, 1'b0, got, lat);
            check_eq($sformatf("col_data_d%0d", d), got, COL_OUT);
            check_eq($sformatf("col_lat_d%0d", d), lat, 4 >> d);
        end

        for (int d = 0; d < 3; d++) begin
            run_block(d, FIPS_OUT, 1'b1, got, lat);
            check_eq($sformatf("inv_data_d%0d", d), got, INV_EN ? FIPS_IN : ref_mix(FIPS_OUT, 1'b0));
            check_eq($sformatf("inv_lat_d%0d", d), lat, 4 >> d);
        end

        // Stall for 10 cycles with a competing block offered, then retire+accept together
        @(negedge clk);
        in_data[0] = COL_IN; inv[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        w = 0;
        while (!out_valid[0] && w < 20) begin @(negedge clk); #1; w++; end
        in_valid[0] = 1'b1;
        in_data[0]  = FIPS_IN;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq($sformatf("bp_valid_%0d", i), out_valid[0], 1'b1);
            check_eq($sformatf("bp_data_%0d", i), out_data[0], COL_OUT);
            check_eq($sformatf("bp_in_ready_%0d", i), in_ready[0], 1'b0);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        #1;
        check_eq("bp_same_edge_in_ready", in_ready[0], 1'b1);
        check_eq("bp_same_edge_out_valid", out_valid[0], 1'b1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b0;
        #1;
        check_eq("bp_retired", out_valid[0], 1'b0);
        check_eq("bp_now_busy", in_ready[0], 1'b0);
        lat = 0;
        while (!out_valid[0] && lat < 20) begin @(negedge clk); #1; lat++; end
        check_eq("bp_next_data", out_data[0], FIPS_OUT);
        check_eq("bp_next_lat", lat, 4);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;

        // Reset while col_cnt is 2 in the single-column instance
        in_data[0] = COL_IN; in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_forces_not_ready", in_ready[1], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid[0], 1'b0);
        check_eq("midrst_out_data", out_data[0], '0);
        check_eq("midrst_in_ready", in_ready[0], 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            seen = seen | out_valid[0];
        end
        check_eq("midrst_no_output", seen, 1'b0);

        for (int d = 0; d < 3; d++) rand_run(d, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
